// File: rtl/nd_2to1.sv
// nd_2to1: two-input, one-output message merge node for the four-phase
// req/ack channel fabric. Messages from rcv0/rcv1 are forwarded one at a
// time, unmodified, on snd0.
//
// Build option: define ND_2TO1_RR_EN for round-robin arbitration on ties.
// Without it, channel 0 has fixed priority.
//
// Handshake contract (every channel, four-phase):
//   sender raises req with dat stable -> receiver raises ack ->
//   sender drops req -> receiver drops ack. A new req may be raised
//   only after the previous ack has fallen.
//
// o_dbg_state exposes the FSM state (0 IDLE, 1 FWD, 2 REL) for checkers.

`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module nd_2to1 #(
    parameter int DSZ = `DATA_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic           i_rcv0_req,
    input  logic [DSZ-1:0] i_rcv0_dat,
    output logic           o_rcv0_ack,
    input  logic           i_rcv1_req,
    input  logic [DSZ-1:0] i_rcv1_dat,
    output logic           o_rcv1_ack,
    output logic           o_snd0_req,
    output logic [DSZ-1:0] o_snd0_dat,
    input  logic           i_snd0_ack,
    output logic           o_last_src,
    output logic [1:0]     o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           req_q, req_d;
    logic           last_q, last_d;
    logic [DSZ-1:0] dat_q, dat_d;

    logic any_req;
    logic pick;      // winning channel index when accepting in IDLE
    logic win_ack;   // ack currently held towards the accepted channel
    logic win_req;   // req of the accepted channel

    assign any_req = i_rcv0_req | i_rcv1_req;

`ifdef ND_2TO1_RR_EN
    // Ties go to the channel that was not served last; a lone request wins.
    assign pick = (i_rcv0_req & i_rcv1_req) ? ~last_q : ~i_rcv0_req;
`else
    // Fixed priority: channel 0 wins whenever it is requesting.
    assign pick = ~i_rcv0_req;
`endif

    // last_q doubles as the index of the in-flight message's source.
    assign win_ack = last_q ? ack1_q : ack0_q;
    assign win_req = last_q ? i_rcv1_req : i_rcv0_req;

    // Next-state logic: accept, forward, release; upstream release runs
    // independently of the downstream side in every non-IDLE state.
    always_comb begin
        state_d = state_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        req_d   = req_q;
        last_d  = last_q;
        dat_d   = dat_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    dat_d   = pick ? i_rcv1_dat : i_rcv0_dat;
                    req_d   = 1'b1;
                    last_d  = pick;
                    if (pick) ack1_d = 1'b1;
                    else      ack0_d = 1'b1;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                if (i_snd0_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                if (!i_snd0_ack && !win_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE && win_ack && !win_req) begin
            if (last_q) ack1_d = 1'b0;
            else        ack0_d = 1'b0;
        end
    end

    // State registers; reset aborts any transfer and drops all req/ack.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            req_q   <= 1'b0;
            last_q  <= 1'b1;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            req_q   <= req_d;
            last_q  <= last_d;
            dat_q   <= dat_d;
        end
    end

    assign o_rcv0_ack  = ack0_q;
    assign o_rcv1_ack  = ack1_q;
    assign o_snd0_req  = req_q;
    assign o_snd0_dat  = dat_q;
    assign o_last_src  = last_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_nd_2to1.sv
// Self-checking bench for nd_2to1: upstream driver tasks, a downstream
// responder that pops an expected-data queue, and one task per scenario.
module tb_nd_2to1;

    localparam int DSZ = 8;

    logic           clk;
    logic           reset;
    logic           i_rcv0_req;
    logic [DSZ-1:0] i_rcv0_dat;
    logic           o_rcv0_ack;
    logic           i_rcv1_req;
    logic [DSZ-1:0] i_rcv1_dat;
    logic           o_rcv1_ack;
    logic           o_snd0_req;
    logic [DSZ-1:0] o_snd0_dat;
    logic           i_snd0_ack;
    logic           o_last_src;
    logic [1:0]     o_dbg_state;

    logic [DSZ-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int ack_delay   = 0;
    bit resp_en     = 1'b1;

    nd_2to1 #(.DSZ(DSZ)) dut (
        .i_clk      (clk),
        .reset      (reset),
        .i_rcv0_req (i_rcv0_req),
        .i_rcv0_dat (i_rcv0_dat),
        .o_rcv0_ack (o_rcv0_ack),
        .i_rcv1_req (i_rcv1_req),
        .i_rcv1_dat (i_rcv1_dat),
        .o_rcv1_ack (o_rcv1_ack),
        .o_snd0_req (o_snd0_req),
        .o_snd0_dat (o_snd0_dat),
        .i_snd0_ack (i_snd0_ack),
        .o_last_src (o_last_src),
        .o_dbg_state(o_dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang want completion");
        $fatal(1, "watchdog");
    end

    // Downstream responder: scoreboard pop on each new request, data/req
    // stability while ack is delayed, then four-phase completion.
    initial begin
        logic [DSZ-1:0] exp;
        int n;
        i_snd0_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && o_snd0_req === 1'b1 && i_snd0_ack === 1'b0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    exp = o_snd0_dat;
                    $display("FAIL snd_unexpected: got message %h want none", o_snd0_dat);
                end else begin
                    exp = exp_q.pop_front();
                    if (o_snd0_dat !== exp) begin
                        miscompares++;
                        $display("FAIL snd_dat: got %h want %h", o_snd0_dat, exp);
                    end
                end
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    vectors++;
                    if (o_snd0_req !== 1'b1 || o_snd0_dat !== exp) begin
                        miscompares++;
                        $display("FAIL snd_stable: got req=%b dat=%h want req=1 dat=%h",
                                 o_snd0_req, o_snd0_dat, exp);
                    end
                end
                i_snd0_ack = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (o_snd0_req !== 1'b0 && n < 50);
                vectors++;
                if (o_snd0_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL snd_req_fall: got %b want 0 after %0d cycles", o_snd0_req, n);
                end
                i_snd0_ack = 1'b0;
            end
        end
    end

    // Upstream driver: one complete four-phase message on channel ch.
    task automatic send(input bit ch, input logic [DSZ-1:0] d);
        int n;
        logic a;
        if (ch) begin
            i_rcv1_dat = d;
            i_rcv1_req = 1'b1;
        end else begin
            i_rcv0_dat = d;
            i_rcv0_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            a = ch ? o_rcv1_ack : o_rcv0_ack;
        end while (a !== 1'b1 && n < 200);
        vectors++;
        if (a !== 1'b1) begin
            miscompares++;
            $display("FAIL rcv%0d_ack_rise: got %b want 1 within %0d cycles", ch, a, n);
        end
        if (ch) i_rcv1_req = 1'b0;
        else    i_rcv0_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            a = ch ? o_rcv1_ack : o_rcv0_ack;
        end while (a !== 1'b0 && n < 20);
        vectors++;
        if (a !== 1'b0) begin
            miscompares++;
            $display("FAIL rcv%0d_ack_fall: got %b want 0 within %0d cycles", ch, a, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        i_rcv0_req = 1'b0;
        i_rcv1_req = 1'b0;
        i_rcv0_dat = '0;
        i_rcv1_dat = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait until every expected message is out and the node is idle.
    task automatic drain();
        int n;
        n = 0;
        while (n < 200 && !(exp_q.size() == 0 && o_snd0_req === 1'b0 && i_snd0_ack === 1'b0 &&
                            o_dbg_state === 2'd0 && o_rcv0_ack === 1'b0 && o_rcv1_ack === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, state=%0d want 0 pending, idle",
                     exp_q.size(), o_dbg_state);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (o_rcv0_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack0: got %b want 0", o_rcv0_ack); end
        if (o_rcv1_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack1: got %b want 0", o_rcv1_ack); end
        if (o_snd0_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", o_snd0_req); end
        if (o_snd0_dat !== '0)   begin miscompares++; $display("FAIL rst_dat: got %h want 0", o_snd0_dat); end
        if (o_last_src !== 1'b1) begin miscompares++; $display("FAIL rst_last: got %b want 1", o_last_src); end
        if (o_dbg_state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", o_dbg_state); end
    endtask

    task automatic test_single();
        exp_q.push_back(8'h05);
        i_rcv0_dat = 8'h05;
        i_rcv0_req = 1'b1;
        @(negedge clk);
        vectors += 4;
        if (o_snd0_req !== 1'b1) begin miscompares++; $display("FAIL single_req: got %b want 1", o_snd0_req); end
        if (o_snd0_dat !== 8'h05) begin miscompares++; $display("FAIL single_dat: got %h want 05", o_snd0_dat); end
        if (o_rcv0_ack !== 1'b1) begin miscompares++; $display("FAIL single_ack0: got %b want 1", o_rcv0_ack); end
        if (o_last_src !== 1'b0) begin miscompares++; $display("FAIL single_last: got %b want 0", o_last_src); end
        i_rcv0_req = 1'b0;
        drain();
    endtask

    task automatic test_tie();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(8'h02);
            exp_q.push_back(8'h07);
            fork
                send(1'b0, 8'h02);
                send(1'b1, 8'h07);
            join
            drain();
            vectors++;
            if (o_last_src !== 1'b1) begin
                miscompares++;
                $display("FAIL tie_last round %0d: got %b want 1", r, o_last_src);
            end
        end
    endtask

    task automatic test_starve();
        do_reset();
`ifdef ND_2TO1_RR_EN
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h03);
        repeat (3) exp_q.push_back(8'h01);
`else
        repeat (4) exp_q.push_back(8'h01);
        exp_q.push_back(8'h03);
`endif
        fork
            send(1'b1, 8'h03);
            begin
                for (int i = 0; i < 4; i++) begin
                    send(1'b0, 8'h01);
`ifndef ND_2TO1_RR_EN
                    vectors++;
                    if (o_rcv1_ack !== 1'b0) begin
                        miscompares++;
                        $display("FAIL starve_ack1 msg %0d: got %b want 0", i, o_rcv1_ack);
                    end
`endif
                end
            end
        join
        drain();
        vectors++;
`ifdef ND_2TO1_RR_EN
        if (o_last_src !== 1'b0) begin miscompares++; $display("FAIL starve_last: got %b want 0", o_last_src); end
`else
        if (o_last_src !== 1'b1) begin miscompares++; $display("FAIL starve_last: got %b want 1", o_last_src); end
`endif
    endtask

    task automatic test_slow_downstream();
        int n;
        ack_delay = 10;
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h06);
        send(1'b0, 8'h0A);
        vectors++;
        if (o_snd0_req !== 1'b1) begin
            miscompares++;
            $display("FAIL slow_upstream_done: got snd_req %b want 1", o_snd0_req);
        end
        fork
            send(1'b1, 8'h06);
            begin
                n = 0;
                while (i_snd0_ack !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                    vectors++;
                    if (o_rcv1_ack !== 1'b0) begin
                        miscompares++;
                        $display("FAIL slow_no_accept: got ack1 %b want 0", o_rcv1_ack);
                    end
                end
                while (i_snd0_ack === 1'b1 && n < 100) begin
                    vectors++;
                    if (o_rcv1_ack !== 1'b0) begin
                        miscompares++;
                        $display("FAIL slow_no_accept_ack: got ack1 %b want 0", o_rcv1_ack);
                    end
                    @(negedge clk);
                    n++;
                end
            end
        join
        ack_delay = 0;
        drain();
    endtask

    task automatic test_reset_mid();
        resp_en = 1'b0;
        i_rcv0_dat = 8'h0C;
        i_rcv0_req = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (o_dbg_state !== 2'd1) begin miscompares++; $display("FAIL mid_in_fwd: got state %0d want 1", o_dbg_state); end
        if (o_snd0_req !== 1'b1) begin miscompares++; $display("FAIL mid_req: got %b want 1", o_snd0_req); end
        reset = 1'b1;
        i_rcv0_req = 1'b0;
        @(negedge clk);
        vectors += 5;
        if (o_rcv0_ack !== 1'b0) begin miscompares++; $display("FAIL mid_ack0: got %b want 0", o_rcv0_ack); end
        if (o_rcv1_ack !== 1'b0) begin miscompares++; $display("FAIL mid_ack1: got %b want 0", o_rcv1_ack); end
        if (o_snd0_req !== 1'b0) begin miscompares++; $display("FAIL mid_req_drop: got %b want 0", o_snd0_req); end
        if (o_snd0_dat !== '0)   begin miscompares++; $display("FAIL mid_dat: got %h want 0", o_snd0_dat); end
        if (o_last_src !== 1'b1) begin miscompares++; $display("FAIL mid_last: got %b want 1", o_last_src); end
        reset = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'h04);
        send(1'b1, 8'h04);
        drain();
        vectors++;
        if (o_last_src !== 1'b1) begin miscompares++; $display("FAIL mid_after_last: got %b want 1", o_last_src); end
    endtask

    task automatic test_back_to_back();
        bit ch;
        logic [DSZ-1:0] d;
        for (int i = 0; i < 8; i++) begin
            ch = 1'($urandom_range(0, 1));
            d  = DSZ'($urandom_range(0, 255));
            ack_delay = $urandom_range(0, 3);
            exp_q.push_back(d);
            send(ch, d);
            drain();
            vectors++;
            if (o_last_src !== ch) begin
                miscompares++;
                $display("FAIL b2b_last msg %0d: got %b want %b", i, o_last_src, ch);
            end
        end
        ack_delay = 0;
    endtask

    // Scenario sequence and final report
    initial begin
        reset      = 1'b1;
        i_rcv0_req = 1'b0;
        i_rcv1_req = 1'b0;
        i_rcv0_dat = '0;
        i_rcv1_dat = '0;
        test_reset();
        test_single();
        test_tie();
        test_starve();
        test_slow_downstream();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
